onehot_phase_sequencer: RTL and testbench

Parametrised successor to the fixed 3-to-8 one-hot decoder in the traffic-light controller. It owns a phase index register and a per-phase dwell timer, and drives a registered N-wide one-hot phase vector. The traffic FSM consumes this vector directly as lamp-group selects. Phase advance is driven by a slow tick enable from the existing clock divider. Dwell times are programmable per phase.

---
 rtl/onehot_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_onehot_phase_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_phase_sequencer.sv
// One-hot phase sequencer: phase index, per-phase programmable dwell timer, registered one-hot output.
// Optional macro PHASE_SKIP_EN adds skip_mask to skip masked phases on advance and start.
module onehot_phase_sequencer #(
  parameter int N_PHASES      = 8,
  parameter int SEL_W         = $clog2(N_PHASES),
  parameter int DWELL_W       = 8,
  parameter int DEFAULT_DWELL = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                hold,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_addr,
  input  logic [DWELL_W-1:0]  cfg_data,
`ifdef PHASE_SKIP_EN
  input  logic [N_PHASES-1:0] skip_mask,
`endif
  output logic [SEL_W-1:0]    phase_idx,
  output logic [N_PHASES-1:0] phase_onehot,
  output logic                phase_step,
  output logic                busy,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell [N_PHASES];

  logic [DWELL_W-1:0] dwell_cur;
  logic [DWELL_W-1:0] last_cnt;
  logic               expire;
  logic               cfg_ok;
  logic [SEL_W-1:0]   adv_idx;
  logic               adv_ok;
  logic [SEL_W-1:0]   first_idx;

  assign fsm_state = state;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return (i == SEL_W'(N_PHASES - 1)) ? '0 : i + 1'b1;
  endfunction

  // A zero dwell behaves as a one-tick dwell; >= keeps cnt from ever wrapping after a shrink.
  assign dwell_cur = dwell[phase_idx];
  assign last_cnt  = (dwell_cur == '0) ? '0 : dwell_cur - 1'b1;
  assign expire    = (cnt >= last_cnt);
  assign cfg_ok    = ({1'b0, cfg_addr} < (SEL_W + 1)'(N_PHASES));

`ifdef PHASE_SKIP_EN
  logic [SEL_W-1:0] probe;
  always_comb begin
    adv_idx   = phase_idx;
    adv_ok    = 1'b0;
    first_idx = '0;
    probe     = phase_idx;
    for (int k = 1; k <= N_PHASES; k++) begin
      probe = wrap_inc(probe);
      if (!adv_ok && !skip_mask[probe]) begin
        adv_ok  = 1'b1;
        adv_idx = probe;
      end
    end
    for (int k = N_PHASES - 1; k >= 0; k--) begin
      if (!skip_mask[k]) first_idx = SEL_W'(k);
    end
  end
`else
  always_comb begin
    adv_idx   = wrap_inc(phase_idx);
    adv_ok    = 1'b1;
    first_idx = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase_idx    <= '0;
      phase_onehot <= '0;
      phase_step   <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      for (int i = 0; i < N_PHASES; i++) dwell[i] <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      phase_step <= 1'b0;
      if (cfg_we && cfg_ok) dwell[cfg_addr] <= cfg_data;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= RUN;
            phase_idx    <= first_idx;
            phase_onehot <= N_PHASES'(1) << first_idx;
            busy         <= 1'b1;
            cnt          <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state        <= IDLE;
            phase_idx    <= '0;
            phase_onehot <= '0;
            busy         <= 1'b0;
            cnt          <= '0;
          end else if (hold) begin
            state <= HOLD;
          end else if (tick) begin
            if (expire) begin
              cnt <= '0;
              // With every phase masked the index stays put and no step is reported.
              if (adv_ok && (adv_idx != phase_idx)) begin
                phase_idx    <= adv_idx;
                phase_onehot <= N_PHASES'(1) << adv_idx;
                phase_step   <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state        <= IDLE;
            phase_idx    <= '0;
            phase_onehot <= '0;
            busy         <= 1'b0;
            cnt          <= '0;
          end else if (!hold) begin
            state <= RUN;
          end
        end
        default: begin
          state        <= IDLE;
          phase_idx    <= '0;
          phase_onehot <= '0;
          busy         <= 1'b0;
          cnt          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_phase_sequencer.sv
// Bench for onehot_phase_sequencer: an 8-phase and a 5-phase instance share stimulus and are
// compared every cycle against a tick-counting reference model of the phase schedule.
module tb_onehot_phase_sequencer;

  localparam int NU = 2;
  localparam int N_OF [NU] = '{8, 5};

  logic       clk = 1'b0;
  logic       reset, tick, start, stop, hold, cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;

  logic [2:0] idx8, idx5;
  logic [7:0] oh8;
  logic [4:0] oh5;
  logic       step8, step5, busy8, busy5;
  logic [1:0] st8, st5;

  logic [2:0] o_idx  [NU];
  logic [7:0] o_oh   [NU];
  logic       o_step [NU];
  logic       o_busy [NU];

  int vectors  = 0;
  int misses   = 0;
  int steps_seen = 0;

  // Reference model: running flag, frozen flag, phase number, ticks spent in phase, dwell table.
  bit m_run  [NU];
  bit m_frz  [NU];
  int m_ph   [NU];
  int m_tk   [NU];
  bit m_step [NU];
  int m_dw   [NU][8];

  always #5 clk = ~clk;

  onehot_phase_sequencer #(.N_PHASES(8)) u8 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .hold(hold),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef PHASE_SKIP_EN
    .skip_mask(8'h00),
`endif
    .phase_idx(idx8), .phase_onehot(oh8), .phase_step(step8), .busy(busy8), .fsm_state(st8)
  );

  onehot_phase_sequencer #(.N_PHASES(5)) u5 (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .hold(hold),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef PHASE_SKIP_EN
    .skip_mask(5'h00),
`endif
    .phase_idx(idx5), .phase_onehot(oh5), .phase_step(step5), .busy(busy5), .fsm_state(st5)
  );

  assign o_idx[0]  = idx8;
  assign o_idx[1]  = idx5;
  assign o_oh[0]   = oh8;
  assign o_oh[1]   = {3'b000, oh5};
  assign o_step[0] = step8;
  assign o_step[1] = step5;
  assign o_busy[0] = busy8;
  assign o_busy[1] = busy5;

  task automatic model_update();
    int lim;
    for (int u = 0; u < NU; u++) begin
      if (reset) begin
        m_run[u] = 0; m_frz[u] = 0; m_ph[u] = 0; m_tk[u] = 0; m_step[u] = 0;
        for (int i = 0; i < 8; i++) m_dw[u][i] = 5;
      end else begin
        m_step[u] = 0;
        if (!m_run[u]) begin
          if (start && !stop) begin
            m_run[u] = 1; m_frz[u] = 0; m_ph[u] = 0; m_tk[u] = 0;
          end
        end else if (stop) begin
          m_run[u] = 0; m_frz[u] = 0; m_ph[u] = 0; m_tk[u] = 0;
        end else if (hold) begin
          m_frz[u] = 1;
        end else if (m_frz[u]) begin
          m_frz[u] = 0;
        end else if (tick) begin
          lim = (m_dw[u][m_ph[u]] == 0) ? 1 : m_dw[u][m_ph[u]];
          if (m_tk[u] + 1 >= lim) begin
            m_ph[u] = (m_ph[u] + 1) % N_OF[u];
            m_tk[u] = 0;
            m_step[u] = 1;
          end else begin
            m_tk[u] = m_tk[u] + 1;
          end
        end
        if (cfg_we && int'(cfg_addr) < N_OF[u]) m_dw[u][cfg_addr] = int'(cfg_data);
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] e_idx;
    logic [7:0] e_oh;
    logic       e_busy;
    for (int u = 0; u < NU; u++) begin
      e_idx  = 3'(m_ph[u]);
      e_busy = m_run[u];
      e_oh   = m_run[u] ? (8'd1 << m_ph[u]) : 8'd0;
      vectors++;
      assert (o_idx[u] === e_idx) else begin
        misses++; $error("FAIL idx n%0d: got %0d want %0d", N_OF[u], o_idx[u], e_idx);
      end
      vectors++;
      assert (o_oh[u] === e_oh) else begin
        misses++; $error("FAIL onehot n%0d: got %h want %h", N_OF[u], o_oh[u], e_oh);
      end
      vectors++;
      assert (o_step[u] === m_step[u]) else begin
        misses++; $error("FAIL step n%0d: got %b want %b", N_OF[u], o_step[u], m_step[u]);
      end
      vectors++;
      assert (o_busy[u] === e_busy) else begin
        misses++; $error("FAIL busy n%0d: got %b want %b", N_OF[u], o_busy[u], e_busy);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    if (step8) steps_seen++;
  endtask

  task automatic idle_inputs();
    reset = 0; tick = 0; start = 0; stop = 0; hold = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic pulse_tick();
    tick = 1; cycle(); tick = 0; cycle();
  endtask

  task automatic write_dwell(input int a, input int d);
    cfg_we = 1; cfg_addr = 3'(a); cfg_data = 8'(d); cycle(); cfg_we = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset with random inputs on everything else.
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick = 1'($urandom); start = 1'($urandom); stop = 1'($urandom); hold = 1'($urandom);
      cfg_we = 1'($urandom); cfg_addr = 3'($urandom); cfg_data = 8'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    // Default dwell of 5 ticks.
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 5; i++) pulse_tick();
    vectors++;
    assert (idx8 === 3'd1) else begin
      misses++; $error("FAIL default_dwell: got %0d want 1", idx8);
    end
    stop = 1; cycle(); stop = 0;

    // Dwell 2 everywhere, 16 ticks: eight steps and a wrap back to phase 0.
    for (int a = 0; a < 8; a++) write_dwell(a, 2);
    start = 1; cycle(); start = 0;
    steps_seen = 0;
    for (int i = 0; i < 16; i++) pulse_tick();
    vectors++;
    assert (steps_seen === 8) else begin
      misses++; $error("FAIL step_count: got %0d want 8", steps_seen);
    end

    // Dwell 1: every tick steps, exercising the 5-phase wrap.
    for (int a = 0; a < 8; a++) write_dwell(a, 1);
    for (int i = 0; i < 12; i++) pulse_tick();

    // Hold freezes through ticks; stop beats hold.
    for (int a = 0; a < 8; a++) write_dwell(a, 3);
    pulse_tick();
    hold = 1;
    for (int i = 0; i < 10; i++) pulse_tick();
    hold = 0; cycle();
    for (int i = 0; i < 4; i++) pulse_tick();
    hold = 1; stop = 1; cycle(); hold = 0; stop = 0;
    vectors++;
    assert (oh8 === 8'h00) else begin
      misses++; $error("FAIL stop_hold: got %h want 00", oh8);
    end

    // Start and stop together in IDLE stays idle.
    start = 1; stop = 1; cycle(); start = 0; stop = 0;

    // Live reprogram of the current phase.
    write_dwell(0, 6);
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 3; i++) pulse_tick();
    write_dwell(0, 2);
    pulse_tick();
    vectors++;
    assert (idx8 === 3'd1) else begin
      misses++; $error("FAIL reprogram: got %0d want 1", idx8);
    end
    write_dwell(0, 0);
    write_dwell(7, 1);
    for (int i = 0; i < 20; i++) pulse_tick();
    // Write and expiring tick in the same cycle.
    cfg_we = 1; cfg_addr = idx5; cfg_data = 8'd9; tick = 1; cycle();
    idle_inputs(); cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick   = ($urandom_range(0, 2) == 0);
      start  = ($urandom_range(0, 40) == 0);
      stop   = ($urandom_range(0, 120) == 0);
      hold   = ($urandom_range(0, 9) == 0) ? ~hold : hold;
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = 8'($urandom_range(0, 6));
      reset  = ($urandom_range(0, 999) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
